// File: rtl/bt_pipeout_sched.sv
// Round-robin scheduler sharing one block-throttled pipe-out endpoint among
// N_CH FWFT channel FIFOs; each block is prefixed with a channel/sequence header.
module bt_pipeout_sched #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned BLOCK_WORDS = 256,
    parameter int unsigned CNT_W       = 11
) (
    input  logic                    ti_clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         ch_enable,
    input  logic [N_CH*CNT_W-1:0]   ch_count,
    input  logic [N_CH*16-1:0]      ch_data,
    output logic [N_CH-1:0]         ch_rd_en,
    output logic                    ep_ready,
    input  logic                    ep_blockstrobe,
    input  logic                    ep_read,
    output logic [15:0]             ep_datain,
    output logic [3:0]              cur_ch,
    output logic                    busy,
    output logic                    err,
    output logic [15:0]             blocks_sent
);

    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned IDX_W  = $clog2(BLOCK_WORDS);
    localparam int unsigned THRESH = BLOCK_WORDS - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_XFER  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     cur_idx_q, cur_idx_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]    word_idx_q, word_idx_d;
    logic                ep_ready_d;
    logic                busy_d;
    logic                err_d;
    logic [15:0]         blocks_d;
    logic                seq_inc;
    logic [7:0]          seq_q [N_CH];

    logic [CNT_W-1:0]    cnt_arr  [N_CH];
    logic [15:0]         data_arr [N_CH];
    logic [N_CH-1:0]     elig_now;
    logic [N_CH-1:0]     elig_q;
    logic [N_CH-1:0]     cand;
    logic                grant_valid;
    logic [CH_W-1:0]     grant_idx;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign cnt_arr[gi]  = ch_count[gi*CNT_W +: CNT_W];
        assign data_arr[gi] = ch_data[gi*16 +: 16];
    end

    // A channel must be eligible both last cycle and now: rising eligibility
    // takes one extra cycle, a dropped enable takes effect immediately.
    always_comb begin
        elig_now = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            elig_now[i] = ch_enable[i] && (32'(cnt_arr[i]) >= THRESH);
        end
        cand = elig_now & elig_q;
    end

    // First candidate at or above rr_q, wrapping.
    always_comb begin
        int unsigned j;
        j           = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            j = (32'(rr_q) + k) % N_CH;
            if (!grant_valid && cand[j]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(j);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cur_idx_d  = cur_idx_q;
        rr_d       = rr_q;
        word_idx_d = word_idx_q;
        ep_ready_d = ep_ready;
        err_d      = err;
        blocks_d   = blocks_sent;
        seq_inc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ep_blockstrobe || ep_read) begin
                    err_d = 1'b1;
                end
                if (grant_valid) begin
                    state_d    = S_ARMED;
                    cur_idx_d  = grant_idx;
                    rr_d       = CH_W'((32'(grant_idx) + 1) % N_CH);
                    ep_ready_d = 1'b1;
                end
            end
            S_ARMED: begin
                if (ep_read) begin
                    err_d = 1'b1;
                end
                if (ep_blockstrobe) begin
                    state_d    = S_XFER;
                    word_idx_d = '0;
                    ep_ready_d = 1'b0;
                end
            end
            S_XFER: begin
                if (ep_blockstrobe) begin
                    err_d = 1'b1;
                end
                if (ep_read) begin
                    if (word_idx_q == LAST_IDX) begin
                        state_d    = S_IDLE;
                        word_idx_d = '0;
                        seq_inc    = 1'b1;
                        blocks_d   = blocks_sent + 16'd1;
                    end else begin
                        word_idx_d = word_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                ep_ready_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge ti_clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cur_idx_q   <= '0;
            rr_q        <= '0;
            word_idx_q  <= '0;
            ep_ready    <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            blocks_sent <= '0;
            elig_q      <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                seq_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            rr_q        <= rr_d;
            word_idx_q  <= word_idx_d;
            ep_ready    <= ep_ready_d;
            busy        <= busy_d;
            err         <= err_d;
            blocks_sent <= blocks_d;
            elig_q      <= elig_now;
            if (seq_inc) begin
                seq_q[cur_idx_q] <= seq_q[cur_idx_q] + 8'd1;
            end
        end
    end

    assign cur_ch = 4'(cur_idx_q);

    // Endpoint data and FIFO pop are combinational so word k is presented in
    // the same cycle its read is sampled; reset suppresses both at once.
    always_comb begin
        ep_datain = '0;
        ch_rd_en  = '0;
        if (rst_n && state_q == S_XFER) begin
            if (word_idx_q == '0) begin
                ep_datain = {4'hA, cur_ch, seq_q[cur_idx_q]};
            end else begin
                ep_datain           = data_arr[cur_idx_q];
                ch_rd_en[cur_idx_q] = ep_read;
            end
        end
    end

endmodule

// File: tb/tb_bt_pipeout_sched.sv
// Directed bench for bt_pipeout_sched: FWFT FIFO models per channel and a
// scoreboard queue of expected endpoint words.
module tb_bt_pipeout_sched;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned BW    = 4;
    localparam int unsigned CNT_W = 11;

    logic                  ti_clk = 1'b0;
    logic                  rst_n;
    logic [N_CH-1:0]       ch_enable;
    logic [N_CH*CNT_W-1:0] ch_count;
    logic [N_CH*16-1:0]    ch_data;
    logic [N_CH-1:0]       ch_rd_en;
    logic                  ep_ready;
    logic                  ep_blockstrobe;
    logic                  ep_read;
    logic [15:0]           ep_datain;
    logic [3:0]            cur_ch;
    logic                  busy;
    logic                  err;
    logic [15:0]           blocks_sent;

    bt_pipeout_sched #(.N_CH(N_CH), .BLOCK_WORDS(BW), .CNT_W(CNT_W)) dut (
        .ti_clk(ti_clk), .rst_n(rst_n), .ch_enable(ch_enable),
        .ch_count(ch_count), .ch_data(ch_data), .ch_rd_en(ch_rd_en),
        .ep_ready(ep_ready), .ep_blockstrobe(ep_blockstrobe), .ep_read(ep_read),
        .ep_datain(ep_datain), .cur_ch(cur_ch), .busy(busy), .err(err),
        .blocks_sent(blocks_sent)
    );

    always #5 ti_clk = ~ti_clk;

    // FIFO models: contents and write pointers owned by the stimulus,
    // read pointers advanced by DUT pops.
    logic [15:0] mem [N_CH][64];
    int          wr_ptr [N_CH];
    int          rd_ptr [N_CH];
    int          pop_cnt [N_CH];
    int          underflows = 0;
    int          multi_hot  = 0;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_fifo
        assign ch_count[gi*CNT_W +: CNT_W] = CNT_W'(wr_ptr[gi] - rd_ptr[gi]);
        assign ch_data[gi*16 +: 16]        = mem[gi][rd_ptr[gi] % 64];
    end

    always @(posedge ti_clk) begin
        if ($countones(ch_rd_en) > 1) multi_hot <= multi_hot + 1;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_rd_en[i]) begin
                if (rd_ptr[i] == wr_ptr[i]) underflows <= underflows + 1;
                else rd_ptr[i] <= rd_ptr[i] + 1;
                pop_cnt[i] <= pop_cnt[i] + 1;
            end
        end
    end

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q [$];
    logic [7:0]  seq_m [N_CH];
    logic [15:0] blocks_m;
    int          exp_next [N_CH];
    int          fill_n [N_CH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int ch, input int k);
        return {4'(ch + 1), 12'(k)};
    endfunction

    task automatic fill(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            mem[ch][wr_ptr[ch] % 64] = pat(ch, fill_n[ch]);
            fill_n[ch]++;
            wr_ptr[ch] = wr_ptr[ch] + 1;
        end
    endtask

    task automatic hold_reset();
        rst_n          = 1'b0;
        ep_blockstrobe = 1'b0;
        ep_read        = 1'b0;
        repeat (2) @(posedge ti_clk);
        for (int i = 0; i < N_CH; i++) seq_m[i] = 8'd0;
        blocks_m = 16'd0;
    endtask

    task automatic release_reset();
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        int k;
        for (k = 0; k < 20; k++) begin
            @(negedge ti_clk);
            if (ep_ready) break;
        end
        chk(tag, 32'(ep_ready), 32'd1);
    endtask

    task automatic run_block(input int ch);
        int p0;
        wait_ready("ready_wait");
        chk("cur_ch", 32'(cur_ch), 32'(ch));
        chk("busy_armed", 32'(busy), 32'd1);
        exp_q.push_back({4'hA, 4'(ch), seq_m[ch]});
        for (int j = 0; j < BW - 1; j++) exp_q.push_back(pat(ch, exp_next[ch] + j));
        p0 = pop_cnt[ch];
        @(posedge ti_clk);
        #1 ep_blockstrobe = 1'b1;
        @(posedge ti_clk);
        #1 ep_blockstrobe = 1'b0;
        ep_read = 1'b1;
        chk("ready_drop", 32'(ep_ready), 32'd0);
        for (int w = 0; w < BW; w++) begin
            logic [15:0] e;
            @(negedge ti_clk);
            e = exp_q.pop_front();
            chk("ep_datain", 32'(ep_datain), 32'(e));
            chk("rd_en", 32'(ch_rd_en), (w == 0) ? 32'd0 : (32'd1 << ch));
            @(posedge ti_clk);
            #1;
        end
        ep_read = 1'b0;
        seq_m[ch]++;
        blocks_m++;
        exp_next[ch] += BW - 1;
        chk("blocks_sent", 32'(blocks_sent), 32'(blocks_m));
        chk("busy_done", 32'(busy), 32'd0);
        chk("pops", 32'(pop_cnt[ch] - p0), 32'(BW - 1));
    endtask

    initial begin
        int p0;
        for (int i = 0; i < N_CH; i++) begin
            wr_ptr[i] = 0; rd_ptr[i] = 0; pop_cnt[i] = 0;
            exp_next[i] = 0; fill_n[i] = 0;
            for (int k = 0; k < 64; k++) mem[i][k] = 16'h0;
        end
        ch_enable = '0;

        // Single channel with exactly BW-1 words.
        hold_reset();
        chk("rst_ready", 32'(ep_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_blocks", 32'(blocks_sent), 32'd0);
        chk("rst_cur_ch", 32'(cur_ch), 32'd0);
        chk("rst_datain", 32'(ep_datain), 32'd0);
        fill(0, 3);
        ch_enable = 4'b0001;
        release_reset();
        @(negedge ti_clk);
        chk("ready_lat0", 32'(ep_ready), 32'd0);
        @(negedge ti_clk);
        chk("ready_lat1", 32'(ep_ready), 32'd0);
        @(negedge ti_clk);
        chk("ready_lat2", 32'(ep_ready), 32'd1);
        run_block(0);
        fill(0, 3);
        run_block(0);
        ch_enable = '0;

        // Round robin over channels 0, 2, 3 from rr_ptr = 0.
        hold_reset();
        fill(0, 6); fill(2, 3); fill(3, 3);
        ch_enable = 4'b1101;
        release_reset();
        run_block(0);
        run_block(2);
        run_block(3);
        run_block(0);
        ch_enable = '0;

        // Eligibility threshold, then enable drop after arming.
        hold_reset();
        fill(1, 2);
        ch_enable = 4'b0010;
        release_reset();
        repeat (6) @(negedge ti_clk);
        chk("thresh_below", 32'(ep_ready), 32'd0);
        @(posedge ti_clk);
        #1 fill(1, 1);
        @(negedge ti_clk);
        chk("thresh_c0", 32'(ep_ready), 32'd0);
        @(negedge ti_clk);
        chk("thresh_c1", 32'(ep_ready), 32'd0);
        @(negedge ti_clk);
        chk("thresh_c2", 32'(ep_ready), 32'd1);
        @(posedge ti_clk);
        #1 ch_enable = 4'b0000;
        run_block(1);
        chk("drop_err", 32'(err), 32'd0);

        // Strobe in IDLE.
        @(posedge ti_clk);
        #1 ep_blockstrobe = 1'b1;
        @(posedge ti_clk);
        #1 ep_blockstrobe = 1'b0;
        chk("idle_strobe_err", 32'(err), 32'd1);
        chk("idle_strobe_busy", 32'(busy), 32'd0);
        chk("idle_strobe_ready", 32'(ep_ready), 32'd0);
        hold_reset();
        release_reset();
        @(negedge ti_clk);
        chk("err_cleared", 32'(err), 32'd0);

        // Stray read while armed.
        fill(2, 3);
        ch_enable = 4'b0100;
        wait_ready("stray_ready");
        @(posedge ti_clk);
        #1 ep_read = 1'b1;
        @(negedge ti_clk);
        chk("stray_rd_en", 32'(ch_rd_en), 32'd0);
        chk("stray_datain", 32'(ep_datain), 32'd0);
        @(posedge ti_clk);
        #1 ep_read = 1'b0;
        chk("stray_err", 32'(err), 32'd1);
        chk("stray_still_armed", 32'(ep_ready), 32'd1);
        run_block(2);
        ch_enable = '0;

        // Reset asserted while word 2 is being read.
        hold_reset();
        fill(1, 3); fill(3, 3);
        ch_enable = 4'b1010;
        release_reset();
        wait_ready("mid_ready");
        chk("mid_cur_ch", 32'(cur_ch), 32'd1);
        p0 = pop_cnt[1];
        @(posedge ti_clk);
        #1 ep_blockstrobe = 1'b1;
        @(posedge ti_clk);
        #1 ep_blockstrobe = 1'b0;
        ep_read = 1'b1;
        @(negedge ti_clk);
        chk("mid_hdr", 32'(ep_datain), 32'h0000A100);
        @(posedge ti_clk);
        #1;
        @(negedge ti_clk);
        chk("mid_d0", 32'(ep_datain), 32'(pat(1, exp_next[1])));
        @(posedge ti_clk);
        #1 rst_n = 1'b0;
        @(negedge ti_clk);
        chk("mid_rst_no_pop", 32'(ch_rd_en), 32'd0);
        @(posedge ti_clk);
        #1 ep_read = 1'b0;
        chk("mid_rst_ready", 32'(ep_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cur_ch", 32'(cur_ch), 32'd0);
        chk("mid_rst_blocks", 32'(blocks_sent), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        chk("mid_rst_datain", 32'(ep_datain), 32'd0);
        chk("mid_rst_pops", 32'(pop_cnt[1] - p0), 32'd1);
        exp_next[1] += 1;
        for (int i = 0; i < N_CH; i++) seq_m[i] = 8'd0;
        blocks_m = 16'd0;
        fill(1, 1);
        @(posedge ti_clk);
        release_reset();
        run_block(1);
        run_block(3);
        ch_enable = '0;

        repeat (3) @(posedge ti_clk);
        chk("no_underflow", 32'(underflows), 32'd0);
        chk("one_hot_pops", 32'(multi_hot), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
